// File: rtl/mem_clk_pkg.sv
// Shared types and defaults for the memory-clock PLL reset sequencer.
// Optional lock-loss counter: MEM_CLK_LOCK_LOSS_CNT_EN.
package mem_clk_pkg;

  typedef enum logic [1:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN
  } clk_state_e;

  // 27 MHz: 10 ms lock timeout, 100 us stability window
  localparam int unsigned RST_CYCLES_DEF    = 32;
  localparam int unsigned LOCK_TIMEOUT_DEF  = 270000;
  localparam int unsigned STABLE_CYCLES_DEF = 2700;

  function automatic int unsigned max3(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/mem_clk_rst_ctrl_sync_2ff.sv
// Two-flop synchroniser for single-bit async inputs.
// Resets to 0 so an unsynchronised input reads as deasserted.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_clk_rst_ctrl.sv
// PLL reset / lock-qualification sequencer for the memory clock.
// Define MEM_CLK_LOCK_LOSS_CNT_EN to build the lock-loss counter.
module mem_clk_rst_ctrl
  import mem_clk_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       mem_rst_n,
  output logic       ready,
  output logic       timeout_err,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned MAX_P =
    max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(RST_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(LOCK_TIMEOUT - 32'd1);
  localparam logic [CNT_W-1:0] ST_LAST =
    CNT_W'(STABLE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  clk_state_e       state_q;
  clk_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             lock_s;
  logic             timeout_hit;
  logic             pll_reset_d;
  logic             mem_rst_n_d;
  logic             ready_d;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PLL_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // relock_req overrides every state transition
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_ONE;
    timeout_hit = 1'b0;
    if (relock_req) begin
      state_d = PLL_RST;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            state_d     = PLL_RST;
            cnt_d       = '0;
            timeout_hit = 1'b1;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == ST_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        RUN: begin
          cnt_d = '0;
          if (!lock_s) begin
            state_d = PLL_RST;
          end
        end
        default: begin
          state_d = PLL_RST;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Decoded from next state so outputs move with the state register
  always_comb begin
    pll_reset_d = 1'b0;
    mem_rst_n_d = 1'b0;
    ready_d     = 1'b0;
    unique case (1'b1)
      (state_d == PLL_RST): begin
        pll_reset_d = 1'b1;
      end
      (state_d == RUN): begin
        mem_rst_n_d = 1'b1;
        ready_d     = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_reset   <= 1'b1;
      mem_rst_n   <= 1'b0;
      ready       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      pll_reset <= pll_reset_d;
      mem_rst_n <= mem_rst_n_d;
      ready     <= ready_d;
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

`ifdef MEM_CLK_LOCK_LOSS_CNT_EN
  logic [7:0] loss_q;
  logic       loss_evt;

  // A requested relock is not a lock loss
  assign loss_evt = (state_q == RUN) && !lock_s && !relock_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= 8'd0;
    end else if (loss_evt && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule
